mux_rr_stream: RTL and testbench

- Parametrised N-channel stream multiplexer; successor to the fixed 8:1 combinational case mux.
- Selects one of CH input channels per cycle and drives a single registered output with valid/ready handshakes on every channel.
- Two modes: fixed select (software-chosen channel) and round-robin scan over the requesting channels.
- Sits between CH producer blocks and one shared downstream consumer.

---
 rtl/mux_rr_stream_if.sv | 27 ++
 rtl/mux_rr_stream.sv | 88 ++++++++
 tb/tb_mux_rr_stream.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_stream_if.sv
// Stream bundle between CH producers, the multiplexer and one shared consumer.
// The slave modport is the multiplexer's view; master is the surrounding system.
interface mux_rr_stream_if #(
    parameter int WIDTH = 4,
    parameter int CH    = 8,
    parameter int SW    = $clog2(CH)
);
    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       in_ready;
    logic                mode;
    logic [SW-1:0]       sel;
    logic [WIDTH-1:0]    out_data;
    logic [SW-1:0]       out_ch;
    logic                out_valid;
    logic                out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_stream.sv
// N-channel stream multiplexer with fixed-select and round-robin arbitration
// feeding a single registered output stage.
module mux_rr_stream #(
    parameter int WIDTH = 4,
    parameter int CH    = 8,
    parameter int SW    = $clog2(CH)
) (
    input logic            clk,
    input logic            rst,
    mux_rr_stream_if.slave bus
);

    logic [SW-1:0]    ptr;
    logic [SW-1:0]    ptr_nxt;
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [SW-1:0]    ch_p1;

    logic             load;
    logic             sel_ok;
    logic             gnt_vld;
    logic [SW-1:0]    gnt;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;
    int               j;
    logic [SW-1:0]    idx;

    assign load   = !vld_p1 || bus.out_ready;
    assign sel_ok = int'(bus.sel) < CH;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        j       = 0;
        idx     = '0;
        if (!bus.mode) begin
            if (sel_ok && bus.in_valid[bus.sel]) begin
                gnt_vld = 1'b1;
                gnt     = bus.sel;
            end
        end else begin
            // Scan starts at ptr and wraps, so the first hit is the fairest requester.
            for (int i = 0; i < CH; i++) begin
                j = int'(ptr) + i;
                if (j >= CH) j = j - CH;
                idx = SW'(j);
                if (!gnt_vld && bus.in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = idx;
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (gnt == SW'(k)) gnt_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    // Ready is suppressed during reset even though the output stage reads as empty.
    assign xfer         = !rst && load && gnt_vld;
    assign bus.in_ready = xfer ? (CH'(1) << gnt) : '0;
    assign ptr_nxt      = (gnt == SW'(CH - 1)) ? '0 : gnt + SW'(1);

    // Stage p1: registered output word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= gnt_data;
            ch_p1   <= gnt;
            if (bus.mode) ptr <= ptr_nxt;
        end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_ch    = ch_p1;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Scoreboard bench for mux_rr_stream: an 8-channel instance for the main
// scenarios and a 6-channel instance for the out-of-range select case.
module tb_mux_rr_stream;

    logic clk;
    logic rst;

    mux_rr_stream_if #(.WIDTH(4), .CH(8), .SW(3)) bus8 ();
    mux_rr_stream_if #(.WIDTH(4), .CH(6), .SW(3)) bus6 ();

    mux_rr_stream #(.WIDTH(4), .CH(8), .SW(3)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    mux_rr_stream #(.WIDTH(4), .CH(6), .SW(3)) u_dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [6:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [2:0] c);
        sb.push_back({c, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got ch=%0d data=%0h expected none",
                             bus8.out_ch, bus8.out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(bus8.out_data), 32'(e[3:0]));
                    chk("out_ch", 32'(bus8.out_ch), 32'(e[6:4]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        bus8.in_data   = 32'h87A5_4321;   // ch0=1 ch1=2 ch2=3 ch3=4 ch4=5 ch5=A ch6=7 ch7=8
        bus8.in_valid  = 8'hFF;
        bus8.mode      = 1'b1;
        bus8.sel       = 3'd0;
        bus8.out_ready = 1'b1;
        bus6.in_data   = 24'h65_4321;     // ch0=1 .. ch5=6
        bus6.in_valid  = 6'h00;
        bus6.mode      = 1'b0;
        bus6.sel       = 3'd0;
        bus6.out_ready = 1'b1;

        // Reset with all channels requesting
        step();
        step();
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus8.out_data), 32'd0);
        chk("rst_out_ch", 32'(bus8.out_ch), 32'd0);
        chk("rst_in_ready", 32'(bus8.in_ready), 32'h00);

        rst = 1'b0;
        #1;
        chk("first_grant", 32'(bus8.in_ready), 32'h01);
        push(4'h1, 3'd0);
        step();                          // ptr -> 1

        // Fixed select on channel 5, one word per cycle
        bus8.mode = 1'b0;
        bus8.sel  = 3'd5;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("fixed_in_ready", 32'(bus8.in_ready), 32'h20);
            push(4'hA, 3'd5);
            step();
        end

        // Round-robin over {0,2,5,7} starting from ptr=1
        bus8.mode     = 1'b1;
        bus8.in_valid = 8'b1010_0101;
        begin
            logic [7:0] rr_rdy [6] = '{8'h04, 8'h20, 8'h80, 8'h01, 8'h04, 8'h20};
            logic [3:0] rr_dat [6] = '{4'h3, 4'hA, 4'h8, 4'h1, 4'h3, 4'hA};
            logic [2:0] rr_ch  [6] = '{3'd2, 3'd5, 3'd7, 3'd0, 3'd2, 3'd5};
            for (int n = 0; n < 6; n++) begin
                #1;
                chk("rr_in_ready", 32'(bus8.in_ready), 32'(rr_rdy[n]));
                push(rr_dat[n], rr_ch[n]);
                step();
            end
        end                              // ptr -> 6

        // Backpressure on a channel-3 word
        bus8.in_valid = 8'h08;
        #1;
        chk("bp_grant3", 32'(bus8.in_ready), 32'h08);
        push(4'h4, 3'd3);
        step();                          // ptr -> 4
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 8'h48;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("bp_in_ready", 32'(bus8.in_ready), 32'h00);
            chk("bp_hold_data", 32'(bus8.out_data), 32'h4);
            chk("bp_hold_ch", 32'(bus8.out_ch), 32'd3);
            step();
        end
        bus8.out_ready = 1'b1;
        #1;
        chk("drain_load", 32'(bus8.in_ready), 32'h40);
        push(4'h7, 3'd6);
        step();                          // ptr -> 7

        // Wrap-around with a sparse request
        bus8.in_valid = 8'b0000_0010;
        #1;
        chk("wrap_grant1", 32'(bus8.in_ready), 32'h02);
        push(4'h2, 3'd1);
        step();                          // ptr -> 2
        bus8.in_valid = 8'b0000_0110;
        #1;
        chk("ptr_is_2", 32'(bus8.in_ready), 32'h04);
        push(4'h3, 3'd2);
        step();                          // ptr -> 3

        // Idle drains the output
        bus8.in_valid = 8'h00;
        #1;
        chk("idle_in_ready", 32'(bus8.in_ready), 32'h00);
        step();
        step();
        chk("idle_out_valid", 32'(bus8.out_valid), 32'd0);

        // Reset while a word is pending; that word is discarded
        bus8.in_valid  = 8'h01;
        bus8.out_ready = 1'b0;
        step();                          // ptr -> 1
        chk("pending_valid", 32'(bus8.out_valid), 32'd1);
        bus8.in_valid = 8'h00;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus8.out_valid), 32'd0);
        chk("async_rst_data", 32'(bus8.out_data), 32'd0);
        step();
        rst            = 1'b0;
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 8'h81;
        #1;
        chk("ptr_after_rst", 32'(bus8.in_ready), 32'h01);
        push(4'h1, 3'd0);
        step();
        bus8.in_valid = 8'h00;
        step();
        step();

        // CH=6 instance: out-of-range select never grants
        bus6.sel      = 3'd7;
        bus6.in_valid = 6'h3F;
        #1;
        chk("ch6_sel7_ready", 32'(bus6.in_ready), 32'h00);
        step();
        chk("ch6_sel7_valid", 32'(bus6.out_valid), 32'd0);
        bus6.sel = 3'd4;
        #1;
        chk("ch6_sel4_ready", 32'(bus6.in_ready), 32'h10);
        step();
        chk("ch6_sel4_data", 32'(bus6.out_data), 32'h5);
        chk("ch6_sel4_ch", 32'(bus6.out_ch), 32'd4);
        chk("ch6_sel4_valid", 32'(bus6.out_valid), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
